// File: rtl/body_regfile_avl.sv
// body_regfile_avl: Avalon-MM shadow/active register file for rendered bodies plus sim control.
// Define BODY_REGFILE_IRQ_EN to build the commit interrupt (IRQ port and CTRL b3 IRQ_EN).
module body_regfile_avl #(
    parameter int NUM_BODIES = 4,
    parameter int ADDR_W     = 7,
    parameter int COORD_W    = 10
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          AVL_CS,
    input  logic                          AVL_READ,
    input  logic                          AVL_WRITE,
    input  logic [3:0]                    AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]             AVL_ADDR,
    input  logic [31:0]                   AVL_WRITEDATA,
    output logic [31:0]                   AVL_READDATA,
    input  logic                          VGA_VS,
    input  logic                          SIM_DONE,
    output logic                          SIM_START,
`ifdef BODY_REGFILE_IRQ_EN
    output logic                          IRQ,
`endif
    output logic [4:0]                    NUM_ACTIVE,
    output logic [15:0]                   FRAME_CNT,
    output logic [NUM_BODIES*COORD_W-1:0] BODY_R,
    output logic [NUM_BODIES*COORD_W-1:0] BODY_X,
    output logic [NUM_BODIES*COORD_W-1:0] BODY_Y,
    output logic [NUM_BODIES*COORD_W-1:0] BODY_Z
);
    localparam int NREG = 4*NUM_BODIES;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_COPY = 2'd2;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    logic [31:0]        shadow_q [NREG];
    logic [31:0]        shadow_d [NREG];
    logic [COORD_W-1:0] act_q    [NREG];
    logic [COORD_W-1:0] act_d    [NREG];
    logic [1:0]         state_q, state_d;
    logic [15:0]        frame_q, frame_d;
    logic [4:0]         num_q, num_d;
    logic [4:0]         num_act_q, num_act_d;
    logic               done_q, done_d;
    logic               start_q, start_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;
`ifdef BODY_REGFILE_IRQ_EN
    logic               irq_en_q, irq_en_d;
    logic               irq_q, irq_d;
`endif

    logic              wr_en, rd_en, ctrl_wr, body_hit, vs_edge, commit, ctrl_b3;
    logic [ADDR_W-1:0] body_off;
    logic [31:0]       rd_word, num_word;

    assign wr_en    = AVL_CS & AVL_WRITE;
    assign rd_en    = AVL_CS & AVL_READ;
    assign ctrl_wr  = wr_en && (AVL_ADDR == ADDR_W'(0)) && AVL_BYTE_EN[0];
    assign body_off = AVL_ADDR - ADDR_W'(4);
    assign body_hit = (AVL_ADDR >= ADDR_W'(4)) && (body_off < ADDR_W'(NREG));
    // Falling edge of the synchronised, active-low vertical sync.
    assign vs_edge  = vs_s3_q & ~vs_s2_q;
    assign commit   = (state_q == ST_PEND) && vs_edge;
    assign num_word = merge_bytes({27'd0, num_q}, AVL_WRITEDATA, AVL_BYTE_EN);
`ifdef BODY_REGFILE_IRQ_EN
    assign ctrl_b3  = irq_en_q;
`else
    assign ctrl_b3  = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        if (AVL_ADDR == ADDR_W'(0))
            rd_word = {28'd0, ctrl_b3, (state_q != ST_IDLE), done_q, 1'b0};
        else if (AVL_ADDR == ADDR_W'(1))
            rd_word = {27'd0, num_q};
        else if (AVL_ADDR == ADDR_W'(2))
            rd_word = {16'd0, frame_q};
        for (int j = 0; j < NREG; j++)
            if (body_hit && (body_off == ADDR_W'(j))) rd_word = shadow_q[j];
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        num_d     = num_q;
        num_act_d = num_act_q;
        done_d    = done_q;
        start_d   = ctrl_wr & AVL_WRITEDATA[0];
        rdata_d   = rd_en ? rd_word : rdata_q;
        vs_s1_d   = VGA_VS;
        vs_s2_d   = vs_s1_q;
        vs_s3_d   = vs_s2_q;
        for (int j = 0; j < NREG; j++) begin
            shadow_d[j] = shadow_q[j];
            act_d[j]    = act_q[j];
        end

        for (int j = 0; j < NREG; j++)
            if (wr_en && body_hit && (body_off == ADDR_W'(j)))
                shadow_d[j] = merge_bytes(shadow_q[j], AVL_WRITEDATA, AVL_BYTE_EN);
        if (wr_en && (AVL_ADDR == ADDR_W'(1)))
            num_d = num_word[4:0];

        if (SIM_DONE)
            done_d = 1'b1;
        else if (ctrl_wr && (AVL_WRITEDATA[0] || AVL_WRITEDATA[1]))
            done_d = 1'b0;

        case (state_q)
            ST_IDLE: if (ctrl_wr && AVL_WRITEDATA[2]) state_d = ST_PEND;
            ST_PEND: if (vs_edge) state_d = ST_COPY;
            ST_COPY: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Copy reads shadow_q, so a bus write landing on the same edge goes to the next commit.
        if (commit) begin
            for (int j = 0; j < NREG; j++) act_d[j] = shadow_q[j][COORD_W-1:0];
            num_act_d = num_q;
            frame_d   = frame_q + 16'd1;
        end

`ifdef BODY_REGFILE_IRQ_EN
        irq_en_d = ctrl_wr ? AVL_WRITEDATA[3] : irq_en_q;
        irq_d    = irq_q;
        if ((wr_en && (AVL_ADDR == ADDR_W'(0))) || (rd_en && (AVL_ADDR == ADDR_W'(2))))
            irq_d = 1'b0;
        if ((state_q == ST_COPY) && irq_en_q)
            irq_d = 1'b1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int j = 0; j < NREG; j++) begin
                shadow_q[j] <= '0;
                act_q[j]    <= '0;
            end
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            num_q     <= '0;
            num_act_q <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            rdata_q   <= '0;
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_s3_q   <= 1'b1;
`ifdef BODY_REGFILE_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            for (int j = 0; j < NREG; j++) begin
                shadow_q[j] <= shadow_d[j];
                act_q[j]    <= act_d[j];
            end
            state_q   <= state_d;
            frame_q   <= frame_d;
            num_q     <= num_d;
            num_act_q <= num_act_d;
            done_q    <= done_d;
            start_q   <= start_d;
            rdata_q   <= rdata_d;
            vs_s1_q   <= vs_s1_d;
            vs_s2_q   <= vs_s2_d;
            vs_s3_q   <= vs_s3_d;
`ifdef BODY_REGFILE_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    assign AVL_READDATA = rdata_q;
    assign SIM_START    = start_q;
    assign FRAME_CNT    = frame_q;
    assign NUM_ACTIVE   = (num_act_q > 5'(NUM_BODIES)) ? 5'(NUM_BODIES) : num_act_q;
`ifdef BODY_REGFILE_IRQ_EN
    assign IRQ          = irq_q;
`endif

    // Radius of bodies beyond the committed count is blanked; X/Y/Z pass through.
    always_comb begin
        BODY_R = '0;
        BODY_X = '0;
        BODY_Y = '0;
        BODY_Z = '0;
        for (int i = 0; i < NUM_BODIES; i++) begin
            BODY_R[i*COORD_W +: COORD_W] = (num_act_q > 5'(i)) ? act_q[4*i] : '0;
            BODY_X[i*COORD_W +: COORD_W] = act_q[4*i+1];
            BODY_Y[i*COORD_W +: COORD_W] = act_q[4*i+2];
            BODY_Z[i*COORD_W +: COORD_W] = act_q[4*i+3];
        end
    end
endmodule
